handshake_sink_arbiter: RTL and testbench

HANDSHAKE_SINK_ARBITER -- requirements
Module: handshake_sink_arbiter

---
 rtl/handshake_sink_arbiter.sv | 162 ++++++++++++++++
 tb/tb_handshake_sink_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sink_arbiter.sv
// handshake_sink_arbiter
// Collects beats from CHANNELS asynchronous 4-phase request/acknowledge sources,
// synchronizes each request, holds the captured data per channel and merges the
// channels round-robin into one valid/ready output register.
// Optional feature: define HANDSHAKE_SINK_ARBITER_PARITY_EN to add per-channel
// even-parity input (sourceParity) and a parity-error flag on the output beat.
module handshake_sink_arbiter #(
    parameter int DATA_WIDTH         = 8,
    parameter int CHANNELS           = 4,
    parameter int SYNCHRONIZER_WIDTH = 2,
    localparam int CW                = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           sinkClock,
    input  logic                           sinkReset,
    input  logic [CHANNELS-1:0]            sourceRequest,
    input  logic [CHANNELS*DATA_WIDTH-1:0] sourceData,
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
    input  logic [CHANNELS-1:0]            sourceParity,
    output logic                           sinkParityError,
`endif
    output logic [CHANNELS-1:0]            sinkAcknowledge,
    output logic                           sinkValid,
    input  logic                           sinkReady,
    output logic [DATA_WIDTH-1:0]          sinkData,
    output logic [CW-1:0]                  sinkChannel
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    logic [SYNCHRONIZER_WIDTH-1:0] r_sync [CHANNELS];
    logic [CHANNELS-1:0]           w_sync_req;
    state_t                        r_state [CHANNELS];
    state_t                        w_state_next [CHANNELS];
    logic [CHANNELS-1:0]           r_ack;
    logic [DATA_WIDTH-1:0]         r_hold_data [CHANNELS];
    logic [CHANNELS-1:0]           w_pending;
    logic                          w_found;
    logic [CW-1:0]                 w_grant_idx;
    logic                          w_grant_fire;
    logic [CW-1:0]                 r_rr_ptr;
    logic                          r_valid;
    logic [DATA_WIDTH-1:0]         r_data;
    logic [CW-1:0]                 r_channel;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
    logic [CHANNELS-1:0]           r_hold_parity;
    logic                          r_parity_error;
`endif

    // Pointer to the channel after idx, wrapping to channel 0.
    function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] idx);
        if (idx == CW'(CHANNELS - 1)) return '0;
        return idx + 1'b1;
    endfunction

    // Request synchronizer chains; only the last flop of each chain is used.
    // NOTE: every clocked block uses <= so all flops sample pre-edge values.
    always_ff @(posedge sinkClock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (sinkReset) r_sync[c] <= '0;
            else           r_sync[c] <= {r_sync[c][SYNCHRONIZER_WIDTH-2:0], sourceRequest[c]};
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_sync_req[c] = r_sync[c][SYNCHRONIZER_WIDTH-1];
            w_pending[c]  = (r_state[c] == ST_PENDING);
        end
    end

    // Round-robin search starting at r_rr_ptr; grant only if the output slot frees up.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && w_pending[(int'(r_rr_ptr) + i) % CHANNELS]) begin
                w_found     = 1'b1;
                w_grant_idx = CW'((int'(r_rr_ptr) + i) % CHANNELS);
            end
        end
        w_grant_fire = w_found && (!r_valid || sinkReady);
    end

    // Per-channel next state: IDLE -> PENDING on request, -> ACK on grant, back on release.
    // NOTE: each output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_state_next[c] = r_state[c];
            case (r_state[c])
                ST_IDLE:    if (w_sync_req[c]) w_state_next[c] = ST_PENDING;
                ST_PENDING: if (w_grant_fire && (w_grant_idx == CW'(c))) w_state_next[c] = ST_ACK;
                ST_ACK:     if (!w_sync_req[c]) w_state_next[c] = ST_IDLE;
                default:    w_state_next[c] = ST_IDLE;
            endcase
        end
    end

    // Channel state and registered acknowledge (high exactly while in ACK).
    always_ff @(posedge sinkClock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (sinkReset) begin
                r_state[c] <= ST_IDLE;
                r_ack[c]   <= 1'b0;
            end else begin
                r_state[c] <= w_state_next[c];
                r_ack[c]   <= (w_state_next[c] == ST_ACK);
            end
        end
    end

    // Capture channel data when a new request is seen in IDLE.
    // NOTE: holding registers carry no reset; the channel state decides whether they are live.
    always_ff @(posedge sinkClock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_state[c] == ST_IDLE && w_sync_req[c]) begin
                r_hold_data[c] <= sourceData[c*DATA_WIDTH +: DATA_WIDTH];
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
                r_hold_parity[c] <= sourceParity[c];
`endif
            end
        end
    end

    // Output register: load on grant, otherwise drop valid once the beat is accepted.
    always_ff @(posedge sinkClock) begin
        if (sinkReset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_channel <= '0;
            r_rr_ptr  <= '0;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
            r_parity_error <= 1'b0;
`endif
        end else if (w_grant_fire) begin
            r_valid   <= 1'b1;
            r_data    <= r_hold_data[w_grant_idx];
            r_channel <= w_grant_idx;
            r_rr_ptr  <= next_ptr(w_grant_idx);
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
            // Even parity: the parity bit equals the XOR of the data bits.
            r_parity_error <= (^r_hold_data[w_grant_idx]) ^ r_hold_parity[w_grant_idx];
`endif
        end else if (sinkReady) begin
            r_valid <= 1'b0;
        end
    end

    assign sinkAcknowledge = r_ack;
    assign sinkValid       = r_valid;
    assign sinkData        = r_data;
    assign sinkChannel     = r_channel;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
    assign sinkParityError = r_parity_error;
`else
    // Without parity the beat carries data and channel only.
`endif

endmodule

// File: tb/tb_handshake_sink_arbiter.sv
// Bench for handshake_sink_arbiter: directed checks of latency, round-robin order,
// back-pressure, held requests and mid-transfer reset, then randomized 4-phase
// sources against a per-channel expected-beat queue model.
module tb_handshake_sink_arbiter;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int SW = 2;
    localparam int QD = 8;

    logic             sinkClock = 1'b0;
    logic             sinkReset;
    logic [CH-1:0]    sourceRequest;
    logic [CH*DW-1:0] sourceData;
    logic [CH-1:0]    sinkAcknowledge;
    logic             sinkValid;
    logic             sinkReady;
    logic [DW-1:0]    sinkData;
    logic [1:0]       sinkChannel;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
    logic [CH-1:0]    sourceParity;
    logic             sinkParityError;
    logic             tb_par [CH];
`endif

    logic          tb_req  [CH];
    logic [DW-1:0] tb_data [CH];

    int n_checks = 0;
    int n_errors = 0;

    // Expected-beat model: one FIFO per channel of data the source has offered.
    logic [DW-1:0] q_buf  [CH][QD];
    int            q_head [CH];
    int            q_tail [CH];
    int            sent;
    int            rcvd;
    bit            rnd_en = 1'b0;
    bit            agents_done;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_chan;

    handshake_sink_arbiter #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .SYNCHRONIZER_WIDTH(SW)
    ) dut (
        .sinkClock      (sinkClock),
        .sinkReset      (sinkReset),
        .sourceRequest  (sourceRequest),
        .sourceData     (sourceData),
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
        .sourceParity   (sourceParity),
        .sinkParityError(sinkParityError),
`endif
        .sinkAcknowledge(sinkAcknowledge),
        .sinkValid      (sinkValid),
        .sinkReady      (sinkReady),
        .sinkData       (sinkData),
        .sinkChannel    (sinkChannel)
    );

    always #5 sinkClock = ~sinkClock;

    always_comb begin
        sourceRequest = '0;
        sourceData    = '0;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
        sourceParity  = '0;
`endif
        for (int c = 0; c < CH; c++) begin
            sourceRequest[c]         = tb_req[c];
            sourceData[c*DW +: DW]   = tb_data[c];
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
            sourceParity[c]          = tb_par[c];
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge sinkClock);
        #1;
    endtask

    task automatic do_reset;
        sinkReset = 1'b1;
        tick;
        tick;
        sinkReset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int t = 0;
        while (!sinkValid && t < limit) begin
            tick;
            t++;
        end
        if (!sinkValid) check(tag, 0, 1);
    endtask

    task automatic wait_ack_low(input int ch, input int limit);
        int t = 0;
        while (sinkAcknowledge[ch] && t < limit) begin
            tick;
            t++;
        end
        if (sinkAcknowledge[ch]) check("ack_low_timeout", 1, 0);
    endtask

    task automatic count_beats(input int ncyc, output int beats,
                               output logic [DW-1:0] last_data, output logic [1:0] last_chan);
        beats     = 0;
        last_data = '0;
        last_chan = '0;
        for (int i = 0; i < ncyc; i++) begin
            if (sinkValid && sinkReady) begin
                beats++;
                last_data = sinkData;
                last_chan = sinkChannel;
            end
            tick;
        end
    endtask

    // One 4-phase source: offer n random words, each waiting for ack then release.
    task automatic source_agent(input int ch, input int n);
        int t;
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) tick;
            d = DW'($urandom);
            tb_data[ch] = d;
            q_buf[ch][q_tail[ch] % QD] = d;
            q_tail[ch]++;
            sent++;
            tb_req[ch] = 1'b1;
            t = 0;
            while (!sinkAcknowledge[ch] && t < 300) begin
                tick;
                t++;
            end
            if (!sinkAcknowledge[ch]) check("ack_rise_timeout", 0, 1);
            repeat ($urandom_range(0, 3)) tick;
            tb_req[ch] = 1'b0;
            wait_ack_low(ch, 50);
        end
    endtask

    // Beat monitor for the random phase: data per channel in order, stable under stall.
    always @(negedge sinkClock) begin
        if (rnd_en) begin
            if (prev_stall) begin
                check("stall_valid", sinkValid, 1);
                check("stall_data", sinkData, prev_data);
                check("stall_chan", sinkChannel, prev_chan);
            end
            prev_stall = sinkValid && !sinkReady;
            prev_data  = sinkData;
            prev_chan  = sinkChannel;
            if (sinkValid && sinkReady) begin
                rcvd++;
                if (q_head[sinkChannel] == q_tail[sinkChannel]) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("beat_data", sinkData, q_buf[sinkChannel][q_head[sinkChannel] % QD]);
                    q_head[sinkChannel]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int            beats;
        logic [DW-1:0] ld;
        logic [1:0]    lc;

        sinkReset = 1'b1;
        sinkReady = 1'b0;
        for (int c = 0; c < CH; c++) begin
            tb_req[c]  = 1'b0;
            tb_data[c] = '0;
`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
            tb_par[c]  = 1'b0;
`endif
        end
        do_reset;
        check("rst_valid", sinkValid, 0);
        check("rst_ack", sinkAcknowledge, 0);
        check("rst_data", sinkData, 0);
        check("rst_chan", sinkChannel, 0);

        // Single request latency and acknowledge life cycle.
        sinkReady  = 1'b1;
        tb_data[1] = 8'hA5;
        tb_req[1]  = 1'b1;
        begin
            int cnt = 0;
            while (!sinkValid && cnt < 20) begin
                tick;
                cnt++;
            end
            check("latency", cnt, SW + 2);
            check("single_data", sinkData, 8'hA5);
            check("single_chan", sinkChannel, 1);
            check("single_ack", sinkAcknowledge, 4'b0010);
            tick;
            check("valid_drop", sinkValid, 0);
            repeat (5) tick;
            check("ack_hold", sinkAcknowledge[1], 1);
            tb_req[1] = 1'b0;
            cnt = 0;
            while (sinkAcknowledge[1] && cnt < 20) begin
                tick;
                cnt++;
            end
            check("ack_fall_latency", cnt, SW + 1);
        end

        // Simultaneous requests: round-robin 0..3, twice.
        do_reset;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < CH; c++) begin
                tb_data[c] = DW'(8'h10 + 8'h10 * r + c);
                tb_req[c]  = 1'b1;
            end
            wait_valid("rr_timeout", 20);
            for (int i = 0; i < CH; i++) begin
                check("rr_valid", sinkValid, 1);
                check("rr_chan", sinkChannel, i);
                check("rr_data", sinkData, 8'h10 + 8'h10 * r + i);
                tick;
            end
            check("rr_end", sinkValid, 0);
            for (int c = 0; c < CH; c++) tb_req[c] = 1'b0;
            for (int c = 0; c < CH; c++) wait_ack_low(c, 20);
        end

        // Back-pressure: beat held, no further grant while stalled.
        sinkReady  = 1'b0;
        tb_data[2] = 8'h5C;
        tb_req[2]  = 1'b1;
        wait_valid("stall_timeout", 20);
        tb_data[0] = 8'h33;
        tb_req[0]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", sinkValid, 1);
            check("hold_data", sinkData, 8'h5C);
            check("hold_chan", sinkChannel, 2);
            check("hold_no_grant", sinkAcknowledge[0], 0);
            tick;
        end
        sinkReady = 1'b1;
        tick;
        check("accept_next_valid", sinkValid, 1);
        check("accept_next_chan", sinkChannel, 0);
        check("accept_next_data", sinkData, 8'h33);
        tick;
        check("accept_drain", sinkValid, 0);
        tb_req[0] = 1'b0;
        tb_req[2] = 1'b0;
        wait_ack_low(0, 20);
        wait_ack_low(2, 20);

        // Request held high after ack: exactly one beat per request edge.
        tb_data[0] = 8'h77;
        tb_req[0]  = 1'b1;
        count_beats(60, beats, ld, lc);
        check("held_beats", beats, 1);
        check("held_data", ld, 8'h77);
        check("held_ack", sinkAcknowledge[0], 1);
        tb_req[0] = 1'b0;
        repeat (6) tick;
        tb_data[0] = 8'h78;
        tb_req[0]  = 1'b1;
        count_beats(20, beats, ld, lc);
        check("rearm_beats", beats, 1);
        check("rearm_data", ld, 8'h78);
        tb_req[0] = 1'b0;
        wait_ack_low(0, 20);

        // Reset with ch1 in the output register and ch3 pending.
        sinkReady  = 1'b0;
        tb_data[1] = 8'h11;
        tb_req[1]  = 1'b1;
        wait_valid("mid_rst_timeout", 20);
        tb_req[1] = 1'b0;
        wait_ack_low(1, 20);
        tb_data[3] = 8'h33;
        tb_req[3]  = 1'b1;
        repeat (SW + 2) tick;
        check("pre_rst_valid", sinkValid, 1);
        sinkReset = 1'b1;
        tick;
        check("mid_rst_valid", sinkValid, 0);
        check("mid_rst_data", sinkData, 0);
        check("mid_rst_chan", sinkChannel, 0);
        check("mid_rst_ack", sinkAcknowledge, 0);
        sinkReset = 1'b0;
        sinkReady = 1'b1;
        count_beats(20, beats, ld, lc);
        check("recapture_beats", beats, 1);
        check("recapture_data", ld, 8'h33);
        check("recapture_chan", lc, 3);
        tb_req[3] = 1'b0;
        wait_ack_low(3, 20);

`ifdef HANDSHAKE_SINK_ARBITER_PARITY_EN
        // 0x07 has three set bits, so its even-parity bit is 1.
        tb_data[0] = 8'h07;
        tb_par[0]  = 1'b0;
        tb_req[0]  = 1'b1;
        wait_valid("par_timeout", 20);
        check("parity_bad", sinkParityError, 1);
        tb_req[0] = 1'b0;
        wait_ack_low(0, 20);
        tick;
        tb_par[0] = 1'b1;
        tb_req[0] = 1'b1;
        wait_valid("par_timeout", 20);
        check("parity_good", sinkParityError, 0);
        tb_req[0] = 1'b0;
        wait_ack_low(0, 20);
        tb_par[0] = 1'b0;
`endif

        // Randomized sources and back-pressure against the queue model.
        do_reset;
        for (int c = 0; c < CH; c++) begin
            q_head[c] = 0;
            q_tail[c] = 0;
        end
        sent        = 0;
        rcvd        = 0;
        prev_stall  = 1'b0;
        agents_done = 1'b0;
        rnd_en      = 1'b1;
        fork
            begin
                fork
                    source_agent(0, 30);
                    source_agent(1, 30);
                    source_agent(2, 30);
                    source_agent(3, 30);
                join
                agents_done = 1'b1;
            end
            begin
                while (!agents_done) begin
                    sinkReady = ($urandom_range(0, 3) != 0);
                    tick;
                end
            end
        join
        sinkReady = 1'b1;
        repeat (10) tick;
        rnd_en = 1'b0;
        for (int c = 0; c < CH; c++) check("drain_ch", q_head[c], q_tail[c]);
        check("beat_total", rcvd, sent);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
